// File: rtl/sp_dram_port_pkg.sv
// sp_dram_port_pkg: shared sizes, types and state encoding for the
// word-to-line DRAM adapter.
package sp_dram_port_pkg;

  localparam int LINE_BYTES      = 16;
  localparam int WORDS_PER_LINE  = 4;
  localparam int LINE_ADDR_WIDTH = 25;

  typedef logic [LINE_ADDR_WIDTH-1:0]        line_t;
  typedef logic [$clog2(WORDS_PER_LINE)-1:0] widx_t;
  typedef logic [LINE_BYTES*8-1:0]           ldata_t;
  typedef logic [LINE_BYTES-1:0]             lmask_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_WR,
    OP_RD
  } op_e;

  function automatic lmask_t word_mask(input widx_t w,
                                       input logic [3:0] be);
    word_mask = lmask_t'(be) << {w, 2'b00};
  endfunction

endpackage

// File: rtl/sp_line_buf.sv
// sp_line_buf: single write-combining line (tag, data, dirty bytes,
// fetched flag) with byte merge, hit detection and word select.
module sp_line_buf
  import sp_dram_port_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  line_t       line,
  input  widx_t       word,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  input  logic        fill_en,
  input  ldata_t      fill_data,
  input  logic        clr_dirty,
  output logic        tag_hit,
  output logic        hit,
  output logic [31:0] rd_word,
  output logic        dirty,
  output line_t       tag,
  output ldata_t      data,
  output lmask_t      bmask
);

  line_t  tag_q, tag_d;
  ldata_t data_q, data_d, bit_mask;
  lmask_t bmask_q, bmask_d, wmask;
  logic   lvalid_q, lvalid_d;

  assign tag_hit = tag_q == line;
  assign rd_word = data_q[{word, 5'b0} +: 32];
  assign hit     = tag_hit &&
                   (lvalid_q || &bmask_q[{word, 2'b00} +: 4]);
  assign dirty   = |bmask_q;
  assign tag     = tag_q;
  assign data    = data_q;
  assign bmask   = bmask_q;

  always_comb begin
    wmask = word_mask(word, wr_be);
    for (int i = 0; i < LINE_BYTES; i++) begin
      bit_mask[8*i +: 8] = {8{wmask[i]}};
    end
  end

  always_comb begin
    tag_d    = tag_q;
    data_d   = data_q;
    bmask_d  = bmask_q;
    lvalid_d = lvalid_q;
    if (clr_dirty) bmask_d = '0;
    if (fill_en) begin
      tag_d    = line;
      data_d   = fill_data;
      bmask_d  = '0;
      lvalid_d = 1'b1;
    end else if (wr_en) begin
      // A new line starts with no fetched data and no dirty bytes
      if (!tag_hit) begin
        bmask_d  = '0;
        lvalid_d = 1'b0;
      end
      tag_d   = line;
      data_d  = (data_q & ~bit_mask) | ({4{wr_data}} & bit_mask);
      bmask_d = bmask_d | wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q    <= '0;
      data_q   <= '0;
      bmask_q  <= '0;
      lvalid_q <= 1'b0;
    end else begin
      tag_q    <= tag_d;
      data_q   <= data_d;
      bmask_q  <= bmask_d;
      lvalid_q <= lvalid_d;
    end
  end

endmodule

// File: rtl/sp_dram_port.sv
// sp_dram_port: 32-bit client words to 128-bit masked DRAM lines.
// Optional idle auto-flush: define SP_DRAM_PORT_FLUSH_TIMER_EN.
module sp_dram_port
  import sp_dram_port_pkg::*;
#(
  parameter int ADDR_WIDTH   = 27,
  parameter int FLUSH_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic [31:0]                din,
  input  logic [3:0]                 be,
  input  logic                       we,
  input  logic                       re,
  output logic                       ready,
  output logic [31:0]                dout,
  output logic                       dout_valid,
  output logic [LINE_ADDR_WIDTH-1:0] mem_addr,
  output logic [127:0]               mem_din,
  output logic [15:0]                mem_mask,
  output logic                       mem_we,
  output logic                       mem_re,
  input  logic [127:0]               mem_dout,
  input  logic                       mem_ready
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  line_t       req_line_q, req_line_d;
  widx_t       req_word_q, req_word_d;
  logic [31:0] req_din_q, req_din_d;
  logic [3:0]  req_be_q, req_be_d;
  logic        wait_first_q, wait_first_d;
  logic [31:0] dout_q, dout_d;
  logic        dout_valid_q, dout_valid_d;

  line_t       in_line, cur_line, buf_tag;
  widx_t       in_word, cur_word;
  logic [31:0] cur_din, buf_word;
  logic [3:0]  cur_be;
  logic        idle, buf_wr, buf_fill, buf_clr;
  logic        tag_hit, hit, dirty, flush_due;
  ldata_t      buf_data;
  lmask_t      buf_bmask;

  assign in_line    = addr[ADDR_WIDTH-1:2];
  assign in_word    = addr[1:0];
  assign idle       = state_q == ST_IDLE;
  assign cur_line   = idle ? in_line : req_line_q;
  assign cur_word   = idle ? in_word : req_word_q;
  assign cur_din    = idle ? din : req_din_q;
  assign cur_be     = idle ? be : req_be_q;
  assign ready      = rst && idle;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

  sp_line_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .line      (cur_line),
    .word      (cur_word),
    .wr_en     (buf_wr),
    .wr_data   (cur_din),
    .wr_be     (cur_be),
    .fill_en   (buf_fill),
    .fill_data (mem_dout),
    .clr_dirty (buf_clr),
    .tag_hit   (tag_hit),
    .hit       (hit),
    .rd_word   (buf_word),
    .dirty     (dirty),
    .tag       (buf_tag),
    .data      (buf_data),
    .bmask     (buf_bmask)
  );

`ifdef SP_DRAM_PORT_FLUSH_TIMER_EN
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;

  assign flush_due = dirty && idle_cnt_q == CW'(FLUSH_CYCLES - 1);

  always_comb begin
    idle_cnt_d = '0;
    if (idle && !we && !re && dirty && !flush_due)
      idle_cnt_d = idle_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) idle_cnt_q <= '0;
    else      idle_cnt_q <= idle_cnt_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = FLUSH_CYCLES != 0;
  assign flush_due  = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    req_line_d   = req_line_q;
    req_word_d   = req_word_q;
    req_din_d    = req_din_q;
    req_be_d     = req_be_q;
    wait_first_d = 1'b0;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    buf_wr       = 1'b0;
    buf_fill     = 1'b0;
    buf_clr      = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_addr     = '0;
    mem_din      = '0;
    mem_mask     = '0;
    if (rst) begin
      unique case (state_q)
        ST_IDLE: begin
          if (we || re) begin
            req_line_d = in_line;
            req_word_d = in_word;
            req_din_d  = din;
            req_be_d   = be;
          end
          if (we) begin
            op_d = OP_WR;
            if (!dirty || tag_hit) buf_wr = 1'b1;
            else state_d = ST_FLUSH;
          end else if (re) begin
            op_d = OP_RD;
            if (hit) begin
              dout_d       = buf_word;
              dout_valid_d = 1'b1;
            end else begin
              state_d = dirty ? ST_FLUSH : ST_RD_REQ;
            end
          end else if (flush_due) begin
            op_d    = OP_NONE;
            state_d = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (mem_ready) begin
            mem_we   = 1'b1;
            mem_addr = buf_tag;
            mem_din  = buf_data;
            mem_mask = buf_bmask;
            buf_clr  = 1'b1;
            unique case (op_q)
              OP_WR: begin
                buf_wr  = 1'b1;
                state_d = ST_IDLE;
              end
              OP_RD:   state_d = ST_RD_REQ;
              default: state_d = ST_IDLE;
            endcase
          end
        end
        ST_RD_REQ: begin
          if (mem_ready) begin
            mem_re       = 1'b1;
            mem_addr     = req_line_q;
            wait_first_d = 1'b1;
            state_d      = ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          // The controller's ready on the cycle right after the strobe is stale
          if (!wait_first_q && mem_ready) begin
            buf_fill     = 1'b1;
            dout_d       = mem_dout[{req_word_q, 5'b0} +: 32];
            dout_valid_d = 1'b1;
            state_d      = ST_RESP;
          end
        end
        ST_RESP: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_NONE;
      req_line_q   <= '0;
      req_word_q   <= '0;
      req_din_q    <= '0;
      req_be_q     <= '0;
      wait_first_q <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      req_line_q   <= req_line_d;
      req_word_q   <= req_word_d;
      req_din_q    <= req_din_d;
      req_be_q     <= req_be_d;
      wait_first_q <= wait_first_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

endmodule

// File: tb/tb_sp_dram_port.sv
// tb_sp_dram_port: directed vector table, reset and idle-flush sequences,
// then random traffic checked against a flat byte-memory reference.
module tb_sp_dram_port;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [26:0]  addr = '0;
  logic [31:0]  din = '0;
  logic [3:0]   be = '0;
  logic         we = 1'b0;
  logic         re = 1'b0;
  logic         ready;
  logic [31:0]  dout;
  logic         dout_valid;
  logic [24:0]  mem_addr;
  logic [127:0] mem_din;
  logic [15:0]  mem_mask;
  logic         mem_we;
  logic         mem_re;
  logic [127:0] mem_dout = '0;
  logic         mem_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_we = 0;
  int n_re = 0;
  int we_cyc = 0;
  int re_cyc = 0;
  bit rnd_ready = 1'b0;
  logic [24:0]  f_addr;
  logic [15:0]  f_mask;
  logic [127:0] f_din;
  logic [127:0] mon_l;

  logic [127:0] dram [int];
  logic [7:0]   ref_mem [int];

  typedef struct {
    bit          w;
    int          line;
    int          word;
    logic [31:0] d;
    logic [3:0]  b;
    logic [31:0] exp_dout;
    int          exp_lat;
    int          exp_nwe;
    int          exp_nre;
    bit          chk_flush;
    int          fa;
    logic [15:0] fm;
    logic [15:0] flo;
    bit          chk_order;
  } vec_t;

  vec_t vt [12];

  sp_dram_port #(.ADDR_WIDTH(27), .FLUSH_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .be(be),
    .we(we), .re(re), .ready(ready), .dout(dout),
    .dout_valid(dout_valid), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_mask(mem_mask), .mem_we(mem_we),
    .mem_re(mem_re), .mem_dout(mem_dout), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int line, input int w);
    return 32'h0123_4567 + 32'(line * 16 + w);
  endfunction

  function automatic logic [127:0] dram_line(input int line);
    logic [127:0] v;
    if (dram.exists(line)) return dram[line];
    for (int w = 0; w < 4; w++) v[32*w +: 32] = init_word(line, w);
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input int line, input int w);
    logic [31:0] v;
    int ba;
    v = init_word(line, w);
    for (int b = 0; b < 4; b++) begin
      ba = line * 16 + w * 4 + b;
      if (ref_mem.exists(ba)) v[8*b +: 8] = ref_mem[ba];
    end
    return v;
  endfunction

  function automatic vec_t mk(bit w, int line, int word, logic [31:0] d,
                              logic [3:0] b, logic [31:0] ed, int el,
                              int nwe, int nre, bit cf, int fa,
                              logic [15:0] fm, logic [15:0] flo, bit co);
    vec_t v;
    v.w = w; v.line = line; v.word = word; v.d = d; v.b = b;
    v.exp_dout = ed; v.exp_lat = el; v.exp_nwe = nwe; v.exp_nre = nre;
    v.chk_flush = cf; v.fa = fa; v.fm = fm; v.flo = flo;
    v.chk_order = co;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!ready) timeout(name);
  endtask

  // DRAM side: records strobes, applies writes, answers reads
  always @(negedge clk) begin
    #1;
    cyc++;
    if (mem_we || mem_re) begin
      checks++;
      if (mem_we && mem_re) begin
        errors++;
        $display("FAIL strobe_overlap: mem_we=1 mem_re=1 required exclusive");
      end
    end
    if (mem_we) begin
      n_we++;
      we_cyc = cyc;
      f_addr = mem_addr;
      f_mask = mem_mask;
      f_din  = mem_din;
      mon_l  = dram_line(int'(mem_addr));
      for (int b = 0; b < 16; b++)
        if (mem_mask[b]) mon_l[8*b +: 8] = mem_din[8*b +: 8];
      dram[int'(mem_addr)] = mon_l;
    end
    if (mem_re) begin
      n_re++;
      re_cyc = cyc;
      mem_dout = dram_line(int'(mem_addr));
    end
  end

  initial forever begin
    @(negedge clk);
    mem_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic run_op(input bit w, input bit r, input int line,
                        input int word, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] got,
                        output int lat);
    wait_ready("ready_before_req");
    we = w; re = r; addr = 27'(line * 4 + word); din = d; be = b;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    got = '0;
    if (r) begin
      lat = 1;
      while (!dout_valid && lat < 500) begin
        @(negedge clk);
        lat++;
      end
      if (!dout_valid) timeout("dout_valid_wait");
      got = dout;
    end else begin
      lat = 0;
      while (!ready && lat < 500) begin
        @(negedge clk);
        lat++;
      end
    end
    wait_ready("ready_after_req");
  endtask

  initial begin
    logic [31:0] got;
    int lat, w0, r0, k;

    vt[0]  = mk(0, 9, 1, 0, 0, init_word(9, 1), 4, 0, 1,
                0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      vt[1+i] = mk(1, 'h10, i, 32'h1000_0000 + 32'(i), 4'hF, 0, 0, 0, 0,
                   0, 0, 0, 0, 0);
    vt[5]  = mk(0, 'h10, 2, 0, 0, 32'h1000_0002, 1, 0, 0,
                0, 0, 0, 0, 0);
    vt[6]  = mk(1, 5, 0, 32'hAABB_CCDD, 4'b0011, 0, -1, 1, 0,
                1, 'h10, 16'hFFFF, 16'h0000, 0);
    vt[7]  = mk(1, 6, 1, 32'h6666_1111, 4'hF, 0, -1, 1, 0,
                1, 5, 16'h0003, 16'hCCDD, 0);
    vt[8]  = mk(1, 3, 0, 32'h3333_0000, 4'hF, 0, -1, 1, 0,
                1, 6, 16'h00F0, 16'h0000, 0);
    vt[9]  = mk(0, 7, 0, 0, 0, init_word(7, 0), -1, 1, 1,
                1, 3, 16'h000F, 16'h0000, 1);
    vt[10] = mk(0, 3, 0, 0, 0, 32'h3333_0000, 4, 0, 1,
                0, 0, 0, 0, 0);
    vt[11] = mk(0, 6, 1, 0, 0, 32'h6666_1111, 4, 0, 1,
                0, 0, 0, 0, 0);

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_mem_strobes", {mem_we, mem_re}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", ready, 1);

    for (int i = 0; i < 12; i++) begin
      w0 = n_we;
      r0 = n_re;
      run_op(vt[i].w, !vt[i].w, vt[i].line, vt[i].word, vt[i].d,
             vt[i].b, got, lat);
      if (!vt[i].w) chk($sformatf("v%0d_dout", i), got, vt[i].exp_dout);
      if (vt[i].exp_lat >= 0)
        chk($sformatf("v%0d_lat", i), lat, vt[i].exp_lat);
      chk($sformatf("v%0d_n_mem_we", i), n_we - w0, vt[i].exp_nwe);
      chk($sformatf("v%0d_n_mem_re", i), n_re - r0, vt[i].exp_nre);
      if (vt[i].chk_flush) begin
        chk($sformatf("v%0d_flush_addr", i), f_addr, vt[i].fa);
        chk($sformatf("v%0d_flush_mask", i), f_mask, vt[i].fm);
        if (vt[i].fm[1:0] == 2'b11)
          chk($sformatf("v%0d_flush_din", i), f_din[15:0], vt[i].flo);
      end
      if (vt[i].chk_order)
        chk($sformatf("v%0d_we_before_re", i), we_cyc < re_cyc, 1);
    end

    // Idle behaviour with a single dirty write
    wait_ready("timer_ready");
    w0 = n_we;
    we = 1'b1; addr = 27'('h30 * 4); din = 32'h5555_AAAA; be = 4'hF;
    @(negedge clk);
    we = 1'b0;
`ifdef SP_DRAM_PORT_FLUSH_TIMER_EN
    k = 1;
    #2;
    while (n_we == w0 && k < 50) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk("timer_flush_cycle", k, 9);
    chk("timer_flush_addr", f_addr, 'h30);
    chk("timer_flush_mask", f_mask, 16'h000F);
`else
    k = 0;
    repeat (1000) @(negedge clk);
    chk("no_timer_flush", n_we - w0, 0);
`endif

    // Reset while waiting on line data
    run_op(0, 1, 'h20, 0, 0, 0, got, lat);
    chk("rst_seq_first_read", got, init_word('h20, 0));
    wait_ready("rst_seq_ready");
    re = 1'b1; addr = 27'('h21 * 4);
    @(negedge clk);
    re = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midwait_rst_ready", ready, 0);
    chk("midwait_rst_strobes", {mem_we, mem_re}, 0);
    chk("midwait_rst_mem_addr", mem_addr, 0);
    chk("midwait_rst_mem_mask", mem_mask, 0);
    chk("midwait_rst_dout_valid", dout_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midwait_release_ready", ready, 1);
    r0 = n_re;
    run_op(0, 1, 'h20, 0, 0, 0, got, lat);
    chk("after_rst_read_misses", n_re - r0, 1);
    chk("after_rst_read_data", got, init_word('h20, 0));

    // Random traffic against the flat reference
    rst = 1'b0;
    repeat (2) @(negedge clk);
    dram.delete();
    ref_mem.delete();
    rst = 1'b1;
    rnd_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 400; i++) begin
      bit w;
      int ln, wd;
      logic [31:0] d;
      logic [3:0] b;
      w  = $urandom_range(0, 9) < 6;
      ln = 'h40 + $urandom_range(0, 3);
      wd = $urandom_range(0, 3);
      d  = $urandom;
      b  = 4'($urandom_range(0, 15));
      run_op(w, !w, ln, wd, d, b, got, lat);
      if (w) begin
        for (int j = 0; j < 4; j++)
          if (b[j]) ref_mem[ln*16 + wd*4 + j] = d[8*j +: 8];
      end else begin
        chk($sformatf("rnd%0d_read_l%0h_w%0d", i, ln, wd), got,
            ref_word(ln, wd));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
